pairing_host_ctrl: RTL and testbench



---
 rtl/pairing_host_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pairing_host_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pairing_host_ctrl.sv
// Host sequencer for one pairing core: loads operands, kicks the core,
// waits for completion, then streams a result window back out.
// Ports: cmd_* command (latched on start), in_* operand stream, out_* result
// stream, core_* pairing core external port and status, idle/done/err_tmo.
module pairing_host_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 304,
  parameter int RD_LAT = 2,
  parameter int FIFO_D = 4,
  parameter int TMO_W  = 24
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [3:0]        cmd_func,
  input  logic [ADDR_W-1:0] cmd_in_base,
  input  logic [ADDR_W-1:0] cmd_out_base,
  input  logic [ADDR_W-1:0] cmd_n_in,
  input  logic [ADDR_W-1:0] cmd_n_out,
  input  logic [TMO_W-1:0]  cmd_tmo,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              core_run,
  output logic [3:0]        core_n_func,
  output logic              core_extin_en,
  output logic [ADDR_W-1:0] core_extin_addr,
  output logic [DATA_W-1:0] core_extin_data,
  output logic [ADDR_W-1:0] core_extout_addr,
  input  logic [DATA_W-1:0] core_extout_data,
  input  logic              core_busy,
  input  logic              core_endflag,
  output logic              idle,
  output logic              done,
  output logic              err_tmo
);

  localparam int CW = $clog2(FIFO_D + 1);
  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam logic [CW:0] FDEPTH = FIFO_D[CW:0];

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KICK, S_WAITB, S_RUN, S_DRAIN, S_FIN
  } state_t;

  state_t state;

  logic [3:0]        func_q;
  logic [ADDR_W-1:0] in_base_q, out_base_q;
  logic [ADDR_W-1:0] n_in_q, n_out_q;
  logic [TMO_W-1:0]  tmo_q, tcnt;
  logic [ADDR_W-1:0] k, j, ck, pc, addr_q;
  logic [RD_LAT-1:0] vsr;
  logic [CW-1:0]     fcnt;
  logic [PW-1:0]     wp, rp;
  logic              err_q;
  logic [DATA_W:0]   mem [FIFO_D];

  function automatic logic [CW-1:0] ones(input logic [RD_LAT-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < RD_LAT; i++) s = s + CW'(v[i]);
    return s;
  endfunction

  logic [CW-1:0]     inflight;
  logic [CW:0]       credit;
  logic              issue, push, pop, tmo_hit, wr_last;
  logic [ADDR_W-1:0] rd_addr;
  state_t            after_run;

  // Reads are only issued while the FIFO can absorb every in-flight word.
  assign inflight  = ones(vsr);
  assign credit    = {1'b0, fcnt} + {1'b0, inflight};
  assign issue     = (state == S_DRAIN) && (j < n_out_q)
                   && (credit < FDEPTH);
  assign rd_addr   = out_base_q + j;
  assign push      = vsr[RD_LAT-1];
  assign pop       = out_valid & out_ready;
  assign wr_last   = (ck == n_out_q - ADDR_W'(1));
  assign tmo_hit   = (tmo_q != '0) && (tcnt >= tmo_q - TMO_W'(1));
  assign after_run = (n_out_q == '0) ? S_FIN : S_DRAIN;

  assign in_ready         = (state == S_LOAD);
  assign core_extin_en    = in_valid & in_ready;
  assign core_extin_addr  = in_ready ? in_base_q + k : '0;
  assign core_extin_data  = core_extin_en ? in_data : '0;
  assign core_extout_addr = issue ? rd_addr : addr_q;
  assign core_run         = (state == S_KICK);
  assign core_n_func      = func_q;
  assign idle             = (state == S_IDLE);
  assign done             = (state == S_FIN);
  assign err_tmo          = err_q;

  assign out_valid = (fcnt != '0);
  assign out_data  = out_valid ? mem[rp][DATA_W-1:0] : '0;
  assign out_last  = out_valid & mem[rp][DATA_W];

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {wr_last, core_extout_data};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      func_q     <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      n_in_q     <= '0;
      n_out_q    <= '0;
      tmo_q      <= '0;
      tcnt       <= '0;
      k          <= '0;
      j          <= '0;
      ck         <= '0;
      pc         <= '0;
      addr_q     <= '0;
      vsr        <= '0;
      fcnt       <= '0;
      wp         <= '0;
      rp         <= '0;
      err_q      <= 1'b0;
    end else begin
      vsr  <= (vsr << 1) | RD_LAT'(issue);
      fcnt <= fcnt + CW'(push) - CW'(pop);
      if (issue) begin
        addr_q <= rd_addr;
        j      <= j + ADDR_W'(1);
      end
      if (push) begin
        wp <= (wp == PW'(FIFO_D - 1)) ? '0 : wp + PW'(1);
        ck <= ck + ADDR_W'(1);
      end
      if (pop) begin
        rp <= (rp == PW'(FIFO_D - 1)) ? '0 : rp + PW'(1);
        pc <= pc + ADDR_W'(1);
      end
      unique case (state)
        S_IDLE: if (start) begin
          func_q     <= cmd_func;
          in_base_q  <= cmd_in_base;
          out_base_q <= cmd_out_base;
          n_in_q     <= cmd_n_in;
          n_out_q    <= cmd_n_out;
          tmo_q      <= cmd_tmo;
          tcnt       <= '0;
          k          <= '0;
          j          <= '0;
          ck         <= '0;
          pc         <= '0;
          err_q      <= 1'b0;
          state      <= (cmd_n_in != '0) ? S_LOAD : S_KICK;
        end
        S_LOAD: if (in_valid) begin
          k <= k + ADDR_W'(1);
          if (k == n_in_q - ADDR_W'(1)) state <= S_KICK;
        end
        S_KICK: begin
          tcnt  <= tcnt + TMO_W'(1);
          state <= S_WAITB;
        end
        S_WAITB: begin
          tcnt <= tcnt + TMO_W'(1);
          if (core_busy && core_endflag) state <= after_run;
          else if (core_busy) state <= S_RUN;
          else if (tmo_hit) begin
            err_q <= 1'b1;
            state <= S_FIN;
          end
        end
        S_RUN: begin
          tcnt <= tcnt + TMO_W'(1);
          if (core_endflag || !core_busy) state <= after_run;
          else if (tmo_hit) begin
            err_q <= 1'b1;
            state <= S_FIN;
          end
        end
        S_DRAIN: if (pop && pc == n_out_q - ADDR_W'(1)) state <= S_FIN;
        S_FIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pairing_host_ctrl.sv
// Randomized bench for pairing_host_ctrl with a behavioural core model,
// operand/result scoreboards and cycle-level timing expectations.
module tb_pairing_host_ctrl;

  localparam int AW = 10;
  localparam int DW = 304;
  localparam int RD_LAT = 2;

  logic          clk = 0;
  logic          rstn = 0;
  logic          start = 0;
  logic [3:0]    cmd_func = 0;
  logic [AW-1:0] cmd_in_base = 0, cmd_out_base = 0;
  logic [AW-1:0] cmd_n_in = 0, cmd_n_out = 0;
  logic [23:0]   cmd_tmo = 0;
  logic          in_valid = 0, in_ready;
  logic [DW-1:0] in_data = 0;
  logic          out_valid, out_ready = 0, out_last;
  logic [DW-1:0] out_data;
  logic          core_run, core_extin_en;
  logic [3:0]    core_n_func;
  logic [AW-1:0] core_extin_addr, core_extout_addr;
  logic [DW-1:0] core_extin_data, core_extout_data;
  logic          core_busy = 0, core_endflag = 0;
  logic          idle, done, err_tmo;

  pairing_host_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .cmd_func(cmd_func),
    .cmd_in_base(cmd_in_base), .cmd_out_base(cmd_out_base),
    .cmd_n_in(cmd_n_in), .cmd_n_out(cmd_n_out), .cmd_tmo(cmd_tmo),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .core_run(core_run), .core_n_func(core_n_func),
    .core_extin_en(core_extin_en), .core_extin_addr(core_extin_addr),
    .core_extin_data(core_extin_data), .core_extout_addr(core_extout_addr),
    .core_extout_data(core_extout_data), .core_busy(core_busy),
    .core_endflag(core_endflag), .idle(idle), .done(done), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [319:0] got,
                     input logic [319:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < 10; i++) w = {w[DW-33:0], 32'($urandom())};
    return w;
  endfunction

  // core model: memory, read pipeline, busy/endflag sequencing
  logic [DW-1:0] cmem    [1024];
  logic [DW-1:0] exp_mem [1024];
  logic [AW-1:0] rd1 = 0, rd2 = 0;
  int bd = 1, rl = 1, hang = 0, bo = 0, bp = 0;

  always @(posedge clk) begin
    if (core_extin_en) cmem[core_extin_addr] <= core_extin_data;
    rd1 <= core_extout_addr;
    rd2 <= rd1;
  end
  assign core_extout_data = cmem[rd2];

  initial forever begin
    @(negedge clk);
    if (core_run && rstn) begin
      repeat (bd) @(posedge clk);
      #1 core_busy = 1;
      if (hang == 0) begin
        if (rl == 0) begin
          core_endflag = 1;
          @(posedge clk);
          #1 core_busy = 0;
          core_endflag = 0;
        end else begin
          repeat (rl) @(posedge clk);
          #1 core_busy = 0;
          core_endflag = (bo == 0);
          @(posedge clk);
          #1 core_endflag = 0;
        end
      end
    end
  end

  // command context and observations
  logic [DW-1:0] words[$];
  logic [3:0]    cur_func = 0;
  logic [AW-1:0] cur_in_base = 0, cur_out_base = 0;
  int cur_n_in = 0, cur_n_out = 0, cur_tmo = 0;
  int cyc = 0, start_cyc = 0;
  int nwr = 0, nrun = 0, npop = 0, ndone = 0, xa_chg = 0;
  int first_rdy = -1, last_wr_cyc = -1, run_cyc = -1, end_cyc = -1;
  int err_cyc = -1, first_pop = -1, last_pop = -1;
  logic          hold_v = 0, prev_busy = 0;
  logic [DW:0]   hold_w = 0;
  logic [AW-1:0] prev_xa = 0, ea;

  // stimulus driver, changes inputs just after the rising edge
  initial forever begin
    @(posedge clk);
    #1;
    if (nwr < cur_n_in) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = words[nwr];
    end else begin
      in_valid = 0;
      in_data  = '0;
    end
    case (bp)
      0: out_ready = 1;
      1: out_ready = !out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // monitor, samples on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!rstn) hold_v = 0;
    else begin
      if (core_extin_en) begin
        ea = AW'(int'(cur_in_base) + nwr);
        if (nwr < words.size()) begin
          chk("wr_addr", core_extin_addr, ea);
          chk("wr_data", core_extin_data, words[nwr]);
          exp_mem[ea] = words[nwr];
        end
        nwr++;
        last_wr_cyc = cyc;
      end
      if (in_ready && first_rdy < 0) first_rdy = cyc;
      if (core_run) begin
        nrun++;
        run_cyc = cyc;
        chk("n_func", core_n_func, cur_func);
      end
      if (end_cyc < 0 && nrun > 0 &&
          (core_endflag || (prev_busy && !core_busy))) end_cyc = cyc;
      if (err_tmo && err_cyc < 0) err_cyc = cyc;
      if (done) ndone++;
      if (core_extout_addr != prev_xa) xa_chg++;
      if (hold_v) chk("stable", {out_valid, out_last, out_data}, {1'b1, hold_w});
      hold_v = 0;
      if (out_valid && out_ready) begin
        ea = AW'(int'(cur_out_base) + npop);
        chk("rd_data", out_data, exp_mem[ea]);
        chk("rd_last", out_last, npop == cur_n_out - 1);
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        npop++;
      end else if (out_valid) begin
        hold_v = 1;
        hold_w = {out_last, out_data};
      end
    end
    prev_busy = core_busy;
    prev_xa = core_extout_addr;
  end

  task automatic check_rst();
    chk("rst_idle", idle, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_run", core_run, 0);
    chk("rst_n_func", core_n_func, 0);
    chk("rst_extin_en", core_extin_en, 0);
    chk("rst_extin_addr", core_extin_addr, 0);
    chk("rst_extin_data", core_extin_data, 0);
    chk("rst_extout_addr", core_extout_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_tmo, 0);
  endtask

  task automatic start_cmd(input logic [3:0] f, input int ib, ni, ob, no,
                           tmo, bdv, rlv, hv, bov, bpv);
    @(posedge clk);
    #1 core_busy = 0;
    core_endflag = 0;
    @(posedge clk);
    #1;
    bd = bdv; rl = rlv; hang = hv; bo = bov; bp = bpv;
    cur_func = f;
    cur_in_base = AW'(ib);
    cur_out_base = AW'(ob);
    cur_n_out = no;
    cur_tmo = tmo;
    words.delete();
    for (int i = 0; i < ni; i++) words.push_back(rnd_word());
    nwr = 0; nrun = 0; npop = 0; ndone = 0; xa_chg = 0;
    first_rdy = -1; last_wr_cyc = -1; run_cyc = -1; end_cyc = -1;
    err_cyc = -1; first_pop = -1; last_pop = -1;
    cur_n_in = ni;
    start = 1;
    cmd_func = f;
    cmd_in_base = AW'(ib);
    cmd_out_base = AW'(ob);
    cmd_n_in = AW'(ni);
    cmd_n_out = AW'(no);
    cmd_tmo = 24'(tmo);
    start_cyc = cyc + 1;
    @(posedge clk);
    #1 start = 0;
    cmd_func = 4'($urandom);
    cmd_in_base = AW'($urandom);
    cmd_out_base = AW'($urandom);
    cmd_n_in = AW'($urandom);
    cmd_n_out = AW'($urandom);
    cmd_tmo = 24'($urandom_range(1, 3));
    @(negedge clk);
    chk("err_clr", err_tmo, 0);
  endtask

  task automatic finish_cmd();
    int t;
    int exp_tmo, exp_pop;
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
      start = 0;
      if (t == 3 && !idle && !done) start = 1;
    end
    start = 0;
    chk("done_seen", done, 1);
    @(negedge clk);
    @(negedge clk);
    exp_tmo = (hang != 0 && cur_tmo != 0) ? 1 : 0;
    exp_pop = (exp_tmo != 0) ? 0 : cur_n_out;
    chk("n_wr", nwr, cur_n_in);
    chk("n_run", nrun, 1);
    if (cur_n_in == 0) chk("run_lat0", run_cyc - start_cyc, 1);
    else begin
      chk("rdy_lat", first_rdy - start_cyc, 1);
      chk("run_lat", run_cyc - last_wr_cyc, 1);
    end
    chk("err_tmo", err_tmo, exp_tmo);
    if (exp_tmo != 0) chk("tmo_cyc", err_cyc - run_cyc, cur_tmo);
    chk("n_pop", npop, exp_pop);
    if (exp_pop == 0) chk("no_rd", xa_chg, 0);
    if (exp_pop != 0 && bp == 0) begin
      chk("rd_lat", first_pop - end_cyc, RD_LAT + 2);
      chk("rd_thru", last_pop - first_pop, exp_pop - 1);
    end
    chk("done_once", ndone, 1);
    chk("idle_end", idle, 1);
  endtask

  task automatic do_cmd(input logic [3:0] f, input int ib, ni, ob, no,
                        tmo, bdv, rlv, hv, bov, bpv);
    start_cmd(f, ib, ni, ob, no, tmo, bdv, rlv, hv, bov, bpv);
    finish_cmd();
  endtask

  initial begin
    logic [DW-1:0] w;
    int t;
    for (int a = 0; a < 1024; a++) begin
      w = rnd_word();
      cmem[a] = w;
      exp_mem[a] = w;
    end
    repeat (3) @(negedge clk);
    check_rst();
    @(posedge clk);
    #1 rstn = 1;

    do_cmd(4'h2, 'h010, 3, 'h020, 2, 0, 5, 3, 0, 0, 0);
    do_cmd(4'h7, 'h3FE, 4, 'h3FD, 5, 0, 2, 2, 0, 0, 0);
    do_cmd(4'h9, 'h050, 2, 'h3FC, 8, 0, 3, 4, 0, 0, 1);
    do_cmd(4'h3, 'h060, 1, 'h070, 3, 100, 5, 0, 1, 0, 0);
    do_cmd(4'h1, 'h000, 0, 'h000, 0, 0, 3, 4, 0, 0, 0);
    do_cmd(4'hC, 'h080, 2, 'h3FE, 3, 0, 2, 0, 0, 0, 0);
    do_cmd(4'h5, 'h090, 2, 'h0A0, 4, 0, 2, 3, 0, 1, 0);

    // async reset while reads are in flight
    start_cmd(4'h5, 'h100, 2, 'h010, 8, 0, 2, 2, 0, 0, 0);
    t = 0;
    while (!core_endflag && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("rst_endflag_seen", core_endflag, 1);
    repeat (3) @(negedge clk);
    rstn = 0;
    #1 check_rst();
    repeat (2) @(negedge clk);
    check_rst();
    @(posedge clk);
    #1 rstn = 1;
    repeat (3) @(negedge clk);
    chk("rst_nodone", ndone, 0);
    do_cmd(4'h6, 'h100, 3, 'h100, 3, 0, 2, 2, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      int ni, no, tm, rlv, bov;
      ni = $urandom_range(0, 6);
      no = $urandom_range(0, 9);
      tm = ($urandom_range(0, 1) != 0) ? $urandom_range(60, 200) : 0;
      bov = $urandom_range(0, 1);
      rlv = $urandom_range(bov, 5);
      do_cmd(4'($urandom), $urandom_range(0, 1023), ni,
             $urandom_range(0, 1023), no, tm, $urandom_range(1, 6),
             rlv, 0, bov, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
